// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
// Shared types and constants for the counter/CSR bank.
//   csr_op_t      : CSR write flavour (plain write, bit set, bit clear)
//   CSR_*         : CSR numbers of the counter block (low-half view; the
//                   high half of a counter sits at +CSR_HIGH_OFFSET)
//   csr_apply_op  : new 32-bit CSR value from the old value, operand and op
// ---------------------------------------------------------------------------
package csr_pkg;

    typedef enum logic [1:0] {
        CSR_WRITE = 2'd0,
        CSR_SET   = 2'd1,
        CSR_CLEAR = 2'd2
    } csr_op_t;

    localparam logic [11:0] CSR_MCYCLE           = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET         = 12'hB02;
    localparam logic [11:0] CSR_MHPMCOUNTER_BASE = 12'hB00;
    localparam logic [11:0] CSR_MHPMEVENT_BASE   = 12'h320;
    localparam logic [11:0] CSR_MCOUNTINHIBIT    = 12'h320;
    localparam logic [11:0] CSR_CYCLE            = 12'hC00;
    localparam logic [11:0] CSR_TIME             = 12'hC01;
    localparam logic [11:0] CSR_INSTRET          = 12'hC02;
    localparam logic [11:0] CSR_HPMCOUNTER_BASE  = 12'hC00;
    localparam logic [11:0] CSR_HIGH_OFFSET      = 12'h080;

    function automatic logic [31:0] csr_apply_op(
        input logic [31:0] old_value,
        input logic [31:0] operand,
        input csr_op_t     op
    );
        case (op)
            CSR_SET:   return old_value | operand;
            CSR_CLEAR: return old_value & ~operand;
            default:   return operand;
        endcase
    endfunction

endpackage

// File: rtl/csr_counter_bank_if.sv
// ---------------------------------------------------------------------------
// csr_counter_bank_if
// CSR access bus between the execute stage (master) and the counter bank
// (slave). Request fields are valid in the issue cycle; csr_read_data and
// csr_illegal are registered and belong to the following cycle.
//   csr_enable        : access valid this cycle (pipe advancing)
//   csr_address[11:0] : CSR number
//   csr_read_enable   : read requested
//   csr_write_enable  : write requested
//   csr_op            : write flavour (csr_op_t)
//   csr_write_data    : write operand
//   csr_read_data     : registered read data
//   csr_illegal       : registered illegal-access flag
// ---------------------------------------------------------------------------
interface csr_counter_bank_if;
    import csr_pkg::*;

    logic        csr_enable;
    logic [11:0] csr_address;
    logic        csr_read_enable;
    logic        csr_write_enable;
    csr_op_t     csr_op;
    logic [31:0] csr_write_data;
    logic [31:0] csr_read_data;
    logic        csr_illegal;

    modport master (
        output csr_enable, csr_address, csr_read_enable, csr_write_enable,
               csr_op, csr_write_data,
        input  csr_read_data, csr_illegal
    );

    modport slave (
        input  csr_enable, csr_address, csr_read_enable, csr_write_enable,
               csr_op, csr_write_data,
        output csr_read_data, csr_illegal
    );

endinterface

// File: rtl/hpm_counter.sv
// ---------------------------------------------------------------------------
// hpm_counter
// One WIDTH-bit counter with independently writable 32-bit halves.
//   clk, reset  : clock, synchronous active-high reset
//   inc         : add one this cycle (ignored while either half is written)
//   write_lo    : replace bits [31:0] with write_value
//   write_hi    : replace bits [WIDTH-1:32] with write_value
//   write_value : 32-bit data for the half being written
//   value       : current count
// ---------------------------------------------------------------------------
module hpm_counter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             write_lo,
    input  logic             write_hi,
    input  logic [31:0]      write_value,
    output logic [WIDTH-1:0] value
);

    // NOTE: state registers use non-blocking assignments so every flop in
    // the design samples its inputs from before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (write_lo) begin
            value[31:0] <= write_value;
        end else if (write_hi) begin
            value[WIDTH-1:32] <= write_value[WIDTH-33:0];
        end else if (inc) begin
            // Full-width add: the carry crosses into the high half and the
            // all-ones value wraps to zero.
            value <= value + WIDTH'(1);
        end
    end

endmodule

// File: rtl/csr_counter_bank.sv
// ---------------------------------------------------------------------------
// csr_counter_bank
// mcycle, minstret and NUM_HPM event-selectable performance counters with
// an inhibit mask, CSR write/set/clear and read-only user shadows.
//   clk, reset : clock, synchronous active-high reset
//   csr_bus    : CSR request/response bus (slave side, 1-cycle read latency)
//   instret    : one instruction retired this cycle
//   events     : per-cycle event pulses; mhpmeventN = k selects events[k-1]
// ---------------------------------------------------------------------------
module csr_counter_bank
    import csr_pkg::*;
#(
    parameter int NUM_HPM       = 4,
    parameter int COUNTER_WIDTH = 64,
    parameter int NUM_EVENTS    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    csr_counter_bank_if.slave     csr_bus,
    input  logic                  instret,
    input  logic [NUM_EVENTS-1:0] events
);

    localparam int        NUM_CNT  = 2 + NUM_HPM;
    localparam logic [5:0] LAST_IDX = 6'(2 + NUM_HPM);
    // Implemented inhibit bits: 0 (cycle), 2 (instret), 3..2+NUM_HPM.
    localparam logic [31:0] INHIBIT_MASK =
        32'(((64'd1 << (NUM_HPM + 3)) - 64'd1) & ~64'd2);

    logic [4:0]               idx;
    logic                     hi_half;
    logic                     in_counter;
    logic                     in_shadow;
    logic                     in_config;
    logic                     idx_counter_ok;
    logic                     idx_shadow_ok;
    logic                     idx_config_ok;
    logic                     access_illegal;
    logic                     write_fire;
    logic [31:0]              cur_value;
    logic [31:0]              write_value;
    logic [31:0]              events_ext;
    logic [31:0]              mcountinhibit;
    logic [4:0]               mhpmevent [32];
    logic [COUNTER_WIDTH-1:0] cnt_value [NUM_CNT];
    logic [63:0]              cnt_view  [32];

    // ---------------- address decode ----------------
    assign idx        = csr_bus.csr_address[4:0];
    assign hi_half    = csr_bus.csr_address[7];
    assign in_counter = (csr_bus.csr_address[11:8] == CSR_MCYCLE[11:8]) &&
                        (csr_bus.csr_address[6:5] == 2'b00);
    assign in_shadow  = (csr_bus.csr_address[11:8] == CSR_CYCLE[11:8]) &&
                        (csr_bus.csr_address[6:5] == 2'b00);
    assign in_config  = (csr_bus.csr_address[11:5] == CSR_MCOUNTINHIBIT[11:5]);

    // Counter slot 1 exists only as the read-only time alias.
    assign idx_counter_ok = (idx == 5'd0) ||
                            (({1'b0, idx} >= 6'd2) && ({1'b0, idx} <= LAST_IDX));
    assign idx_shadow_ok  = ({1'b0, idx} <= LAST_IDX);
    assign idx_config_ok  = (idx == 5'd0) ||
                            (({1'b0, idx} >= 6'd3) && ({1'b0, idx} <= LAST_IDX));

    assign access_illegal = !((in_counter && idx_counter_ok) ||
                              (in_shadow && idx_shadow_ok && !csr_bus.csr_write_enable) ||
                              (in_config && idx_config_ok));

    assign write_fire = csr_bus.csr_enable && csr_bus.csr_write_enable && !access_illegal;

    // ---------------- read mux (full 64-bit view per CSR index) ----------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < 32; k++) begin
            cnt_view[k] = '0;
        end
        cnt_view[0] = 64'(cnt_value[0]);
        cnt_view[1] = 64'(cnt_value[0]);
        cnt_view[2] = 64'(cnt_value[1]);
        for (int g = 2; g < NUM_CNT; g++) begin
            cnt_view[g + 1] = 64'(cnt_value[g]);
        end
    end

    always_comb begin
        cur_value = '0;
        if (in_config) begin
            cur_value = (idx == 5'd0) ? mcountinhibit : {27'd0, mhpmevent[idx]};
        end else if (hi_half) begin
            cur_value = cnt_view[idx][63:32];
        end else begin
            cur_value = cnt_view[idx][31:0];
        end
    end

    assign write_value = csr_apply_op(cur_value, csr_bus.csr_write_data, csr_bus.csr_op);

    // Bit k of events_ext is events[k-1]; bit 0 and bits past NUM_EVENTS are
    // zero, so out-of-range selectors never count.
    assign events_ext = 32'(events) << 1;

    // ---------------- configuration and response registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mcountinhibit         <= '0;
            csr_bus.csr_read_data <= '0;
            csr_bus.csr_illegal   <= 1'b0;
            // NOTE: the selector file is tiny and must read 0 after reset,
            // so every entry is reset rather than left uninitialised.
            for (int k = 0; k < 32; k++) begin
                mhpmevent[k] <= '0;
            end
        end else begin
            csr_bus.csr_illegal <= csr_bus.csr_enable && access_illegal;
            if (csr_bus.csr_enable && csr_bus.csr_read_enable) begin
                csr_bus.csr_read_data <= access_illegal ? 32'd0 : cur_value;
            end
            if (write_fire && in_config) begin
                if (idx == 5'd0) begin
                    mcountinhibit <= write_value & INHIBIT_MASK;
                end else begin
                    mhpmevent[idx] <= write_value[4:0];
                end
            end
        end
    end

    // ---------------- counters ----------------
    for (genvar g = 0; g < NUM_CNT; g++) begin : g_counter
        // CSR index of this counter: mcycle 0, minstret 2, mhpmcounterN N.
        localparam int         CIDX  = (g == 0) ? 0 : ((g == 1) ? 2 : g + 1);
        localparam logic [4:0] CIDX5 = 5'(CIDX);

        logic inc;
        logic hit;

        if (g == 0) begin : g_cycle
            assign inc = !mcountinhibit[0];
        end else if (g == 1) begin : g_instret
            assign inc = instret && !mcountinhibit[2];
        end else begin : g_event
            assign inc = events_ext[mhpmevent[CIDX5]] && !mcountinhibit[CIDX];
        end

        assign hit = write_fire && in_counter && (idx == CIDX5);

        hpm_counter #(
            .WIDTH (COUNTER_WIDTH)
        ) u_counter (
            .clk         (clk),
            .reset       (reset),
            .inc         (inc),
            .write_lo    (hit && !hi_half),
            .write_hi    (hit && hi_half),
            .write_value (write_value),
            .value       (cnt_value[g])
        );
    end

endmodule

// File: tb/tb_csr_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_csr_counter_bank
// Self-checking bench for csr_counter_bank. A behavioural model keeps every
// counter as a plain 64-bit number indexed by CSR number and recomputes the
// expected response of each cycle from the address map and counting rules.
// ---------------------------------------------------------------------------
module tb_csr_counter_bank;
    import csr_pkg::*;

    localparam int NUM_HPM       = 4;
    localparam int COUNTER_WIDTH = 64;
    localparam int NUM_EVENTS    = 8;
    localparam logic [63:0] CMASK = {64{1'b1}} >> (64 - COUNTER_WIDTH);

    localparam logic [11:0] RAND_ADDRS [24] = '{
        12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB83, 12'hB06, 12'hB86,
        12'hC00, 12'hC01, 12'hC81, 12'hC02, 12'hC82, 12'hC05, 12'hC85, 12'h320,
        12'h323, 12'h326, 12'hB01, 12'hB07, 12'hC07, 12'h321, 12'h324, 12'hFFF
    };

    logic                  clk;
    logic                  reset;
    logic                  instret;
    logic [NUM_EVENTS-1:0] events;

    csr_counter_bank_if bus ();

    csr_counter_bank #(
        .NUM_HPM       (NUM_HPM),
        .COUNTER_WIDTH (COUNTER_WIDTH),
        .NUM_EVENTS    (NUM_EVENTS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .csr_bus (bus),
        .instret (instret),
        .events  (events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // stimulus levels held across steps
    bit                  rst_drv     = 1'b1;
    bit                  instret_drv = 1'b0;
    logic [NUM_EVENTS-1:0] events_drv = '0;

    // model state
    logic [63:0] m_cnt [32];
    logic [4:0]  m_evt [32];
    logic [31:0] m_inh;
    logic [31:0] exp_rd;
    bit          exp_ill;

    function automatic bit m_legal(input logic [11:0] a, input bit we);
        int v = int'(a);
        if (v >= 'hB00 && v <= 'hB02 + NUM_HPM && v != 'hB01) return 1'b1;
        if (v >= 'hB80 && v <= 'hB82 + NUM_HPM && v != 'hB81) return 1'b1;
        if (v >= 'hC00 && v <= 'hC02 + NUM_HPM) return !we;
        if (v >= 'hC80 && v <= 'hC82 + NUM_HPM) return !we;
        if (v == 'h320) return 1'b1;
        if (v >= 'h323 && v <= 'h322 + NUM_HPM) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        int          k = int'(a) % 32;
        logic [63:0] src;
        if (int'(a) >= 'h320 && int'(a) < 'h340) begin
            return (k == 0) ? m_inh : {27'd0, m_evt[k]};
        end
        src = (k == 1) ? m_cnt[0] : m_cnt[k];
        return ((int'(a) % 256) >= 128) ? src[63:32] : src[31:0];
    endfunction

    function automatic logic [31:0] m_op(input csr_op_t op, input logic [31:0] o, input logic [31:0] d);
        if (op == CSR_SET)   return o | d;
        if (op == CSR_CLEAR) return o & ~d;
        return d;
    endfunction

    function automatic bit m_counts(input int c);
        int s;
        if (c == 0) return !m_inh[0];
        if (c == 2) return instret_drv && !m_inh[2];
        if (c < 3 || c > 2 + NUM_HPM) return 1'b0;
        s = int'(m_evt[c]);
        if (s < 1 || s > NUM_EVENTS) return 1'b0;
        return events_drv[s-1] && !m_inh[c];
    endfunction

    function automatic logic [31:0] m_inh_mask();
        logic [31:0] m = '0;
        for (int b = 0; b < 32; b++) m[b] = (b == 0) || (b >= 2 && b <= 2 + NUM_HPM);
        return m;
    endfunction

    // One clock cycle: drive the request, advance the model, settle past the edge.
    task automatic step(input bit en, input logic [11:0] addr, input bit re, input bit we,
                        input csr_op_t op, input logic [31:0] wd);
        bit          legal;
        logic [31:0] old_v;
        logic [31:0] v;
        logic [63:0] nxt [32];
        int          k;
        bus.csr_enable       = en;
        bus.csr_address      = addr;
        bus.csr_read_enable  = re;
        bus.csr_write_enable = we;
        bus.csr_op           = op;
        bus.csr_write_data   = wd;
        reset                = rst_drv;
        instret              = instret_drv;
        events               = events_drv;
        legal = m_legal(addr, we);
        old_v = m_read(addr);
        @(posedge clk);
        if (rst_drv) begin
            for (int c = 0; c < 32; c++) begin
                m_cnt[c] = '0;
                m_evt[c] = '0;
            end
            m_inh   = '0;
            exp_rd  = '0;
            exp_ill = 1'b0;
        end else begin
            exp_ill = en && !legal;
            if (en && re) exp_rd = legal ? old_v : 32'd0;
            nxt = m_cnt;
            for (int c = 0; c < 32; c++) begin
                if (m_counts(c)) nxt[c] = (m_cnt[c] + 64'd1) & CMASK;
            end
            if (en && we && legal) begin
                v = m_op(op, old_v, wd);
                k = int'(addr) % 32;
                if (int'(addr) >= 'hB00 && int'(addr) < 'hC00) begin
                    if ((int'(addr) % 256) >= 128) nxt[k] = {v, m_cnt[k][31:0]} & CMASK;
                    else                           nxt[k] = {m_cnt[k][63:32], v};
                end else if (k == 0) begin
                    m_inh = v & m_inh_mask();
                end else begin
                    m_evt[k] = v[4:0];
                end
            end
            m_cnt = nxt;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 12'h000, 1'b0, 1'b0, CSR_WRITE, 32'd0);
    endtask

    task automatic rd(input logic [11:0] a);
        step(1'b1, a, 1'b1, 1'b0, CSR_WRITE, 32'd0);
    endtask

    task automatic wr(input logic [11:0] a, input csr_op_t op, input logic [31:0] d);
        step(1'b1, a, 1'b0, 1'b1, op, d);
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_drv = 1'b1;
        repeat (3) idle();
        checks++;
        if (bus.csr_read_data !== 32'd0) begin
            errors++; $display("FAIL reset_read_data: got %h want 00000000", bus.csr_read_data);
        end
        checks++;
        if (bus.csr_illegal !== 1'b0) begin
            errors++; $display("FAIL reset_illegal: got %b want 0", bus.csr_illegal);
        end
    endtask

    task automatic test_cycle_count();
        rst_drv = 1'b0;
        repeat (10) idle();
        rd(12'hC00);
        checks++;
        if (bus.csr_read_data !== 32'd10 || exp_rd !== 32'd10) begin
            errors++; $display("FAIL cycle_at_10: got %0d want 10", bus.csr_read_data);
        end
        checks++;
        if (bus.csr_illegal !== 1'b0) begin
            errors++; $display("FAIL cycle_illegal: got %b want 0", bus.csr_illegal);
        end
        rd(12'hC01);
        checks++;
        if (bus.csr_read_data !== exp_rd || exp_rd !== 32'd11) begin
            errors++; $display("FAIL time_alias: got %0d want 11", bus.csr_read_data);
        end
    endtask

    task automatic test_carry_wrap();
        wr(12'hB00, CSR_WRITE, 32'hFFFF_FFFF);
        wr(12'hB80, CSR_WRITE, 32'h0);
        idle();
        rd(12'hB80);
        checks++;
        if (bus.csr_read_data !== 32'd1) begin
            errors++; $display("FAIL carry_hi: got %h want 00000001", bus.csr_read_data);
        end
        wr(12'hB00, CSR_WRITE, 32'hFFFF_FFFF);
        wr(12'hB80, CSR_WRITE, 32'hFFFF_FFFF);
        idle();
        rd(12'hB00);
        checks++;
        if (bus.csr_read_data !== 32'd0) begin
            errors++; $display("FAIL wrap_lo: got %h want 00000000", bus.csr_read_data);
        end
        rd(12'hB80);
        checks++;
        if (bus.csr_read_data !== 32'd0) begin
            errors++; $display("FAIL wrap_hi: got %h want 00000000", bus.csr_read_data);
        end
    endtask

    task automatic test_event_select();
        wr(12'h323, CSR_WRITE, 32'd2);
        wr(12'hB03, CSR_WRITE, 32'd0);
        wr(12'hB83, CSR_WRITE, 32'd0);
        events_drv = 8'h02;
        repeat (5) idle();
        events_drv = 8'h01;
        repeat (7) idle();
        events_drv = '0;
        rd(12'hB03);
        checks++;
        if (bus.csr_read_data !== 32'd5) begin
            errors++; $display("FAIL event_count: got %0d want 5", bus.csr_read_data);
        end
        wr(12'h323, CSR_WRITE, 32'd9);
        events_drv = 8'hFF;
        repeat (6) idle();
        events_drv = '0;
        rd(12'hB03);
        checks++;
        if (bus.csr_read_data !== 32'd5) begin
            errors++; $display("FAIL event_sel_out_of_range: got %0d want 5", bus.csr_read_data);
        end
        wr(12'h324, CSR_WRITE, 32'hFFFF_FFE9);
        rd(12'h324);
        checks++;
        if (bus.csr_read_data !== 32'h9) begin
            errors++; $display("FAIL event_5bit: got %h want 00000009", bus.csr_read_data);
        end
        wr(12'h324, CSR_WRITE, 32'd0);
    endtask

    task automatic test_inhibit();
        logic [31:0] snap_cycle;
        logic [31:0] snap_inst;
        instret_drv = 1'b1;
        wr(12'h320, CSR_SET, 32'h5);
        snap_cycle = m_read(12'hB00);
        snap_inst  = m_read(12'hB02);
        repeat (20) idle();
        rd(12'hB00);
        checks++;
        if (bus.csr_read_data !== snap_cycle) begin
            errors++; $display("FAIL inhibit_cycle: got %h want %h", bus.csr_read_data, snap_cycle);
        end
        rd(12'hB02);
        checks++;
        if (bus.csr_read_data !== snap_inst) begin
            errors++; $display("FAIL inhibit_instret: got %h want %h", bus.csr_read_data, snap_inst);
        end
        wr(12'h320, CSR_CLEAR, 32'h1);
        snap_cycle = m_read(12'hB00);
        repeat (5) idle();
        rd(12'hB00);
        checks++;
        if (bus.csr_read_data !== snap_cycle + 32'd5) begin
            errors++; $display("FAIL cycle_resumed: got %h want %h", bus.csr_read_data, snap_cycle + 32'd5);
        end
        rd(12'hB02);
        checks++;
        if (bus.csr_read_data !== snap_inst) begin
            errors++; $display("FAIL instret_still_frozen: got %h want %h", bus.csr_read_data, snap_inst);
        end
        rd(12'h320);
        checks++;
        if (bus.csr_read_data !== 32'h4) begin
            errors++; $display("FAIL inhibit_readback: got %h want 00000004", bus.csr_read_data);
        end
        wr(12'h320, CSR_WRITE, 32'h2);
        rd(12'h320);
        checks++;
        if (bus.csr_read_data !== 32'h0) begin
            errors++; $display("FAIL inhibit_bit1_zero: got %h want 00000000", bus.csr_read_data);
        end
        instret_drv = 1'b0;
    endtask

    task automatic test_write_vs_inc();
        wr(12'h323, CSR_WRITE, 32'd1);
        wr(12'hB83, CSR_WRITE, 32'd0);
        events_drv = 8'h01;
        wr(12'hB03, CSR_WRITE, 32'h100);
        rd(12'hB03);
        checks++;
        if (bus.csr_read_data !== 32'h100) begin
            errors++; $display("FAIL write_wins: got %h want 00000100", bus.csr_read_data);
        end
        rd(12'hB03);
        checks++;
        if (bus.csr_read_data !== 32'h101) begin
            errors++; $display("FAIL inc_resumes: got %h want 00000101", bus.csr_read_data);
        end
        events_drv = '0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] old_v;
        old_v = m_read(12'hB03);
        step(1'b1, 12'hB03, 1'b1, 1'b1, CSR_WRITE, 32'h55);
        checks++;
        if (bus.csr_read_data !== old_v) begin
            errors++; $display("FAIL rw_same_old: got %h want %h", bus.csr_read_data, old_v);
        end
        rd(12'hB03);
        checks++;
        if (bus.csr_read_data !== 32'h55) begin
            errors++; $display("FAIL rw_same_new: got %h want 00000055", bus.csr_read_data);
        end
        step(1'b1, 12'hB03, 1'b1, 1'b1, CSR_SET, 32'h0F00);
        rd(12'hB03);
        checks++;
        if (bus.csr_read_data !== 32'h0F55) begin
            errors++; $display("FAIL set_op: got %h want 00000f55", bus.csr_read_data);
        end
        wr(12'hB03, CSR_CLEAR, 32'h0505);
        rd(12'hB03);
        checks++;
        if (bus.csr_read_data !== 32'h0A50) begin
            errors++; $display("FAIL clear_op: got %h want 00000a50", bus.csr_read_data);
        end
    endtask

    task automatic test_illegal();
        wr(12'hC00, CSR_WRITE, 32'h0);
        checks++;
        if (bus.csr_illegal !== 1'b1) begin
            errors++; $display("FAIL write_shadow_illegal: got %b want 1", bus.csr_illegal);
        end
        rd(12'hC00);
        checks++;
        if (bus.csr_read_data !== exp_rd || bus.csr_illegal !== 1'b0) begin
            errors++; $display("FAIL cycle_unaffected: got %h/%b want %h/0", bus.csr_read_data, bus.csr_illegal, exp_rd);
        end
        rd(12'hB07);
        checks++;
        if (bus.csr_illegal !== 1'b1 || bus.csr_read_data !== 32'd0) begin
            errors++; $display("FAIL read_b07: got %h/%b want 00000000/1", bus.csr_read_data, bus.csr_illegal);
        end
        rd(12'hB01);
        checks++;
        if (bus.csr_illegal !== 1'b1) begin
            errors++; $display("FAIL read_b01: got %b want 1", bus.csr_illegal);
        end
        idle();
        checks++;
        if (bus.csr_illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_one_cycle: got %b want 0", bus.csr_illegal);
        end
    endtask

    task automatic test_random();
        logic [11:0] a;
        for (int n = 0; n < 300; n++) begin
            a           = RAND_ADDRS[$urandom_range(0, 23)];
            instret_drv = 1'($urandom_range(0, 1));
            events_drv  = NUM_EVENTS'($urandom);
            step(($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), csr_op_t'($urandom_range(0, 2)), $urandom);
            checks++;
            if (bus.csr_read_data !== exp_rd || bus.csr_illegal !== exp_ill) begin
                errors++;
                $display("FAIL random_%0d addr %h: got %h/%b want %h/%b", n, a,
                         bus.csr_read_data, bus.csr_illegal, exp_rd, exp_ill);
            end
        end
        instret_drv = 1'b0;
        events_drv  = '0;
    endtask

    task automatic test_reset_pending();
        logic [11:0] a;
        rd(12'hB00);
        rst_drv = 1'b1;
        rd(12'hB02);
        checks++;
        if (bus.csr_read_data !== 32'd0 || bus.csr_illegal !== 1'b0) begin
            errors++; $display("FAIL reset_drops_read: got %h/%b want 00000000/0", bus.csr_read_data, bus.csr_illegal);
        end
        rst_drv = 1'b0;
        rd(12'hB00);
        checks++;
        if (bus.csr_read_data !== 32'd0) begin
            errors++; $display("FAIL post_reset_mcycle: got %h want 00000000", bus.csr_read_data);
        end
        for (int i = 0; i < 2 * NUM_HPM + 6; i++) begin
            if (i < NUM_HPM + 1)        a = 12'hB02 + 12'(i);
            else if (i < 2 * NUM_HPM + 2) a = 12'hB82 + 12'(i - NUM_HPM - 1);
            else if (i == 2 * NUM_HPM + 2) a = 12'hB80;
            else                        a = 12'h320 + 12'(i - 2 * NUM_HPM - 3 + (i > 2 * NUM_HPM + 3 ? 2 : 0));
            rd(a);
            checks++;
            if (bus.csr_read_data !== 32'd0) begin
                errors++; $display("FAIL post_reset_zero addr %h: got %h want 00000000", a, bus.csr_read_data);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cycle_count();
        test_carry_wrap();
        test_event_select();
        test_inhibit();
        test_write_vs_inc();
        test_back_to_back();
        test_illegal();
        test_random();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_counter_bank.md
Name: csr_counter_bank

Overview:
Parametrised counter/CSR unit replacing the core's fixed cycle/instret counters and hardwired CSR read decode.
- Provides mcycle, minstret and NUM_HPM programmable hardware performance counters, each selecting one of NUM_EVENTS event lines.
- Supports an inhibit mask and CSR write/set/clear, with read-only user shadows.
- Sits at the execute/memory boundary: the request is issued from EX and data returns one cycle later for WB.

Parameters:
- NUM_HPM, 4, number of mhpmcounterN/mhpmeventN pairs (N = 3..3+NUM_HPM-1), range 0..29.
- COUNTER_WIDTH, 64, counter width, range 33..64; bits above the width read 0.
- NUM_EVENTS, 8, width of the event input, range 1..31.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- csr_enable  in  1  access valid this cycle (pipe advancing)
- csr_address  in  12  CSR number
- csr_read_enable  in  1  read requested
- csr_write_enable  in  1  write requested
- csr_op  in  2  csr_op_t: CSR_WRITE, CSR_SET, CSR_CLEAR
- csr_write_data  in  32  write operand
- csr_read_data  out  32  registered read data
- csr_illegal  out  1  registered illegal-access flag
- instret  in  1  one instruction retired this cycle (already pipe-qualified)
- events  in  NUM_EVENTS  per-cycle event pulses

Behaviour:
- Reset: all counters, mhpmevent, mcountinhibit, csr_read_data and csr_illegal are 0. Reset wins over every other action in the same cycle; a request pending at reset is dropped.
- Address map (full view):
  - mcycle 0xB00/0xB80, minstret 0xB02/0xB82
  - mhpmcounterN 0xB00+N / 0xB80+N
  - mhpmeventN 0x320+N
  - mcountinhibit 0x320
  - read-only shadows cycle 0xC00/0xC80, time 0xC01/0xC81 (alias of cycle), instret 0xC02/0xC82, hpmcounterN 0xC00+N / 0xC80+N
- Read latency is 1 cycle. Sampling occurs only when csr_enable && csr_read_enable: csr_read_data takes the pre-update value at the issue cycle; otherwise it holds its value.
- csr_illegal is set to 1 for one cycle when csr_enable and either condition holds:
  - the address is unimplemented (including N beyond NUM_HPM, and 0xB01/0xB81);
  - a write targets 0xCxx.
  Illegal accesses read 0 and change no state.
- Write value is computed against the current CSR value:
  - CSR_WRITE: d
  - CSR_SET: old | d
  - CSR_CLEAR: old & ~d
- Low-half write replaces bits [31:0] only; high-half write replaces bits [COUNTER_WIDTH-1:32] only.
- A write to a counter takes precedence over that counter's increment in the same cycle. The written value is visible on a read issued the next cycle, and increments resume the cycle after that.
- Increment rules (+1 per cycle, wraps to 0 after all-ones, carry propagates across halves):
  - mcycle: every cycle unless mcountinhibit[0].
  - minstret: when instret && !mcountinhibit[2].
  - mhpmcounterN: when sel = mhpmeventN, 1 <= sel <= NUM_EVENTS, events[sel-1] && !mcountinhibit[N].
  - sel = 0 or sel > NUM_EVENTS means the counter never increments.
- mhpmeventN stores 5 bits; upper write bits are discarded and read back as 0.
- mcountinhibit: bit 1 and bits beyond 2+NUM_HPM are hardwired 0.
- Simultaneous read and write to the same CSR returns the old value.

Decomposition:
- Package csr_pkg holds:
  - csr_op_t
  - address constants (CSR_MCYCLE, CSR_MINSTRET, CSR_MHPMCOUNTER_BASE, CSR_MHPMEVENT_BASE, CSR_MCOUNTINHIBIT, CSR_CYCLE, CSR_TIME, CSR_INSTRET, CSR_HPMCOUNTER_BASE, high-half offset 0x80)
  - function csr_apply_op(old, d, op)
- Sub-module hpm_counter (parameter WIDTH): ports clk, reset, inc, write_lo, write_hi, write_value, value. Instantiated 2+NUM_HPM times via generate; the top level holds decode, event select, inhibit and the read mux.

Test Plan:
- Cycle counting: release reset, issue a read of 0xC00 at cycle 10 after release -> csr_read_data=10 at cycle 11, csr_illegal=0. Read 0xC01 -> same value as 0xC00.
- Carry and wrap: write 0xB00=0xFFFFFFFF and 0xB80=0, wait 2 cycles, read 0xB80 -> 1. Write both halves all-ones -> a read 2 cycles later sees low=0 and high=0.
- Event select: write 0x323=2, pulse events[1] for 5 cycles and events[0] for 7 -> 0xB03 reads 5. Set 0x323=9 (NUM_EVENTS=8) -> the counter stays frozen.
- Inhibit and set/clear: CSR_SET 0x320 with 0x5 -> mcycle and minstret frozen over 20 cycles with instret=1. CSR_CLEAR 0x320 with 0x1 -> mcycle resumes, minstret stays frozen. A read of 0x320 returns 0x4; writing 0x2 to 0x320 reads back 0x0.
- Write-vs-increment: write mhpmcounter3=0x100 while its event is active -> the next-cycle read returns 0x100, the read one cycle later returns 0x101.
- Illegal and reset: write 0xC00 -> csr_illegal=1 and cycle unaffected. Read 0xB07 with NUM_HPM=4 -> csr_illegal=1, data 0. Assert reset during a pending read -> csr_read_data=0 and all counters read 0 afterwards.
